// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default framing constants.
package uart_pkg;

  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pad; resets to the idle-high level.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // Shift the raw line through two flops before the FSM looks at it
  always_comb begin
    sync_d = {sync_q[0], rx};
  end

  // Synchroniser flops; reset to 1 so a reset never looks like a start bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rx_s = sync_q[1];

endmodule

// File: rtl/uart_rx_core.sv
// Parametrised oversampled UART receiver with false-start reject, framing/parity
// error flags and a valid/ack output handshake with overrun pulse.
// Optional feature: define UART_RX_PARITY_EN to expect one parity bit after data.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 ack,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(DATA_BITS + 1);

  localparam logic [OS_W-1:0] OS_MID    = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_ONE    = OS_W'(1);
  localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_BITS - 1);
  localparam logic [BC_W-1:0] STOP_LAST = BC_W'(STOP_BITS - 1);
  localparam logic [BC_W-1:0] BC_ONE    = BC_W'(1);

  if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_os
    $error("uart_rx_core: OVERSAMPLE must be even and >= 4");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_db
    $error("uart_rx_core: DATA_BITS must be 5..9");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_sb
    $error("uart_rx_core: STOP_BITS must be 1 or 2");
  end
  if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_po
    $error("uart_rx_core: PARITY_ODD must be 0 or 1");
  end

  logic rx_s;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .rx_s  (rx_s)
  );

  rx_state_t            state_q,      state_d;
  logic [OS_W-1:0]      os_cnt_q,     os_cnt_d;
  logic [BC_W-1:0]      bit_cnt_q,    bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q,      shreg_d;
  logic                 ferr_acc_q,   ferr_acc_d;
  logic [DATA_BITS-1:0] data_q,       data_d;
  logic                 valid_q,      valid_d;
  logic                 frame_err_q,  frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q,    overrun_d;
  logic                 frame_done;
  logic                 frame_ferr;
  logic                 frame_perr;

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic perr_acc_q, perr_acc_d;
`endif

  // Frame FSM: start qualification, bit sampling, stop checking and output handshake
  always_comb begin
    state_d      = state_q;
    os_cnt_d     = os_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    ferr_acc_d   = ferr_acc_q;
    data_d       = data_q;
    valid_d      = valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = 1'b0;
    frame_done   = 1'b0;
    frame_ferr   = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_acc_d   = perr_acc_q;
    frame_perr   = perr_acc_q;
`else
    frame_perr   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        os_cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end

      START: begin
        if (os_cnt_q == OS_MID) begin
          os_cnt_d = '0;
          // A line that is high again at mid start bit was only a glitch
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end else begin
          os_cnt_d = os_cnt_q + OS_ONE;
        end
      end

      DATA: begin
        if (os_cnt_q == OS_LAST) begin
          os_cnt_d = '0;
          shreg_d  = {rx_s, shreg_q[DATA_BITS-1:1]};
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d  = '0;
            ferr_acc_d = 1'b0;
`ifdef UART_RX_PARITY_EN
            state_d    = PARITY;
`else
            state_d    = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BC_ONE;
          end
        end else begin
          os_cnt_d = os_cnt_q + OS_ONE;
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (os_cnt_q == OS_LAST) begin
          os_cnt_d   = '0;
          perr_acc_d = rx_s ^ (^shreg_q) ^ PAR_ODD;
          state_d    = STOP;
        end else begin
          os_cnt_d = os_cnt_q + OS_ONE;
        end
      end
`endif

      STOP: begin
        if (os_cnt_q == OS_LAST) begin
          os_cnt_d = '0;
          if (bit_cnt_q == STOP_LAST) begin
            // Return to IDLE at once so a back-to-back start bit is not missed
            frame_done = 1'b1;
            frame_ferr = ferr_acc_q | ~rx_s;
            bit_cnt_d  = '0;
            state_d    = IDLE;
          end else begin
            ferr_acc_d = ferr_acc_q | ~rx_s;
            bit_cnt_d  = bit_cnt_q + BC_ONE;
          end
        end else begin
          os_cnt_d = os_cnt_q + OS_ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (valid_q && ack) begin
      valid_d = 1'b0;
    end

    // A completed frame loads only if the previous word is gone or being taken now
    if (frame_done) begin
      if (!valid_q || ack) begin
        data_d       = shreg_q;
        frame_err_d  = frame_ferr;
        parity_err_d = frame_perr;
        valid_d      = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State, counters, shift register and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      os_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      ferr_acc_q   <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_acc_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      os_cnt_q     <= os_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      ferr_acc_q   <= ferr_acc_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      perr_acc_q   <= perr_acc_d;
`endif
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed scenarios plus randomized frames
// compared against a frame-level reference model. Honours UART_RX_PARITY_EN.
module tb_uart_rx_core;

  localparam int OS   = 16;
  localparam int DB   = 8;
  localparam int SB   = 1;
  localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int PB   = 1;
`else
  localparam int PB   = 0;
`endif
  localparam int NBITS     = DB + PB + SB;
  localparam int FRAME_CYC = (1 + NBITS) * OS;
  localparam int DONE_OFS  = 3 + OS / 2 + NBITS * OS;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx;
  logic          ack;
  logic [DB-1:0] data;
  logic          valid;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model of the output register set
  logic [DB-1:0] m_data;
  logic          m_valid;
  logic          m_ferr;
  logic          m_perr;

  uart_rx_core #(
    .OVERSAMPLE (OS),
    .DATA_BITS  (DB),
    .STOP_BITS  (SB),
    .PARITY_ODD (PODD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .ack        (ack),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic exp_ovr);
    check({tag, ".data"},       32'(data),       32'(m_data));
    check({tag, ".valid"},      32'(valid),      32'(m_valid));
    check({tag, ".frame_err"},  32'(frame_err),  32'(m_ferr));
    check({tag, ".parity_err"}, 32'(parity_err), 32'(m_perr));
    check({tag, ".overrun"},    32'(overrun),    32'(exp_ovr));
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    m_valid = 1'b0;
    check_outputs({tag, ".ack"}, 1'b0);
  endtask

  // Drive one whole frame starting at this negedge; check latency, busy and completion
  task automatic send_frame(input logic [DB-1:0] d, input logic par_flip,
                            input logic [1:0] stop_vals, input logic ack_at_done,
                            input string tag);
    logic fbits [0:NBITS];
    logic good_par;
    logic exp_ferr;
    logic exp_perr;
    logic ack_in;
    logic exp_ovr;
    good_par = logic'((($countones(d) + PODD) % 2) != 0);
    fbits[0] = 1'b0;
    for (int i = 0; i < DB; i++) fbits[1 + i] = d[i];
`ifdef UART_RX_PARITY_EN
    fbits[1 + DB] = good_par ^ par_flip;
    exp_perr = par_flip;
`else
    exp_perr = 1'b0;
`endif
    exp_ferr = 1'b0;
    for (int s = 0; s < SB; s++) begin
      fbits[1 + DB + PB + s] = stop_vals[s];
      if (!stop_vals[s]) exp_ferr = 1'b1;
    end
    for (int t = 0; t < FRAME_CYC; t++) begin
      rx = fbits[t / OS];
      if (t == 2) check({tag, ".busy_pre"}, 32'(busy), 32'(0));
      if (t == 3) check({tag, ".busy_on"},  32'(busy), 32'(1));
      if (t == DONE_OFS - 1) begin
        check({tag, ".valid_early"}, 32'(valid), 32'(m_valid));
        check({tag, ".ovr_early"},   32'(overrun), 32'(0));
        if (ack_at_done) ack = 1'b1;
      end
      if (t == DONE_OFS) begin
        ack_in = ack;
        ack    = 1'b0;
        if (!m_valid || ack_in) begin
          m_data  = d;
          m_ferr  = exp_ferr;
          m_perr  = exp_perr;
          m_valid = 1'b1;
          exp_ovr = 1'b0;
        end else begin
          exp_ovr = 1'b1;
        end
        check_outputs({tag, ".done"}, exp_ovr);
        check({tag, ".busy_off"}, 32'(busy), 32'(0));
      end
      if (t == DONE_OFS + 1) check({tag, ".ovr_pulse"}, 32'(overrun), 32'(0));
      @(negedge clk);
    end
    rx = 1'b1;
  endtask

  initial begin
    logic [DB-1:0] rd;
    logic          stop_err;
    reset = 1'b1;
    rx    = 1'b1;
    ack   = 1'b0;
    m_data = '0; m_valid = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs("reset", 1'b0);
    check("reset.busy", 32'(busy), 32'(0));
    reset = 1'b0;
    idle(5);

    // Clean frame, then acknowledge
    send_frame(8'hA5, 1'b0, 2'b11, 1'b0, "a5");
    idle(3);
    do_ack("a5");

    // Short low glitch is rejected as a false start
    for (int t = 0; t < 30; t++) begin
      rx = (t < 4) ? 1'b0 : 1'b1;
      if (t == 3)  check("glitch.busy_on",  32'(busy), 32'(1));
      if (t == 11) check("glitch.busy_off", 32'(busy), 32'(0));
      @(negedge clk);
    end
    check_outputs("glitch", 1'b0);

    // Framing error, then a clean frame clears the flag
    send_frame(8'h3C, 1'b0, 2'b00, 1'b0, "ferr");
    idle(24);
    do_ack("ferr");
    send_frame(8'h42, 1'b0, 2'b11, 1'b0, "clean42");
    idle(2);
    do_ack("clean42");

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x01 needs parity bit 1; sending 0 must flag an error
    send_frame(8'h01, 1'b1, 2'b11, 1'b0, "par_bad");
    idle(2);
    do_ack("par_bad");
    send_frame(8'h01, 1'b0, 2'b11, 1'b0, "par_ok");
    idle(2);
    do_ack("par_ok");
`endif

    // Back-to-back without ack: second frame overruns
    send_frame(8'h11, 1'b0, 2'b11, 1'b0, "b2b_1");
    send_frame(8'h22, 1'b0, 2'b11, 1'b0, "b2b_2");
    // Ack on the completion cycle accepts and reloads in one go
    send_frame(8'h33, 1'b0, 2'b11, 1'b1, "ack_done");
    idle(4);

    // Reset in the middle of the data bits of 0xFF
    for (int t = 0; t < 4 * OS; t++) begin
      rx = (t < OS) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    check("rst_mid.busy_pre", 32'(busy), 32'(1));
    reset = 1'b1;
    #1;
    m_data = '0; m_valid = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
    check_outputs("rst_mid", 1'b0);
    check("rst_mid.busy", 32'(busy), 32'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(OS);
    send_frame(8'h5A, 1'b0, 2'b11, 1'b0, "after_rst");
    idle(2);

    // Randomized frames with random errors, acks and gaps
    for (int i = 0; i < 24; i++) begin
      rd       = DB'($urandom);
      stop_err = ($urandom_range(0, 3) == 0);
      send_frame(rd, 1'($urandom_range(0, 1)), stop_err ? 2'b00 : 2'b11,
                 ($urandom_range(0, 4) == 0), $sformatf("rnd%0d", i));
      if (stop_err) idle(20 + $urandom_range(0, 5));
      else          idle($urandom_range(0, 6));
      if ($urandom_range(0, 1) == 1) do_ack($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
